// File: rtl/cache_front_end_arb_if.sv
// Bundles the requester-side and back-end-side signals of the multi-port cache front-end.
// master: the requesters plus cache back-end environment; slave: the arbiter.
interface cache_front_end_arb_if #(
   parameter int FE_ADDR_W   = 32,
   parameter int FE_DATA_W   = 32,
   parameter int N_PORTS     = 2,
   parameter int CTRL_CACHE  = 0,
   parameter int CTRL_ADDR_W = 5
);
   localparam int FE_NBYTES = FE_DATA_W / 8;
   localparam int FE_BYTE_W = $clog2(FE_NBYTES);
   localparam int PTR_W     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
   localparam int AW        = CTRL_CACHE + FE_ADDR_W;
   localparam int WA_W      = FE_ADDR_W - FE_BYTE_W;

   logic [N_PORTS-1:0]           valid;
   logic [N_PORTS*AW-1:0]        addr;
   logic [N_PORTS*FE_DATA_W-1:0] wdata;
   logic [N_PORTS*FE_NBYTES-1:0] wstrb;
   logic [N_PORTS-1:0]           ready;
   logic [N_PORTS*FE_DATA_W-1:0] rdata;

   logic                         data_valid;
   logic [WA_W-1:0]              data_addr;
   logic [FE_DATA_W-1:0]         data_rdata;
   logic                         data_ready;
   logic                         data_valid_reg;
   logic [WA_W-1:0]              data_addr_reg;
   logic [FE_DATA_W-1:0]         data_wdata_reg;
   logic [FE_NBYTES-1:0]         data_wstrb_reg;

   logic                         ctrl_valid;
   logic [CTRL_ADDR_W-1:0]       ctrl_addr;
   logic [FE_DATA_W-1:0]         ctrl_rdata;
   logic                         ctrl_ready;

   logic [PTR_W-1:0]             grant_id;

   modport master (
      output valid, addr, wdata, wstrb, data_rdata, data_ready, ctrl_rdata, ctrl_ready,
      input  ready, rdata, data_valid, data_addr, data_valid_reg, data_addr_reg,
             data_wdata_reg, data_wstrb_reg, ctrl_valid, ctrl_addr, grant_id
   );

   modport slave (
      input  valid, addr, wdata, wstrb, data_rdata, data_ready, ctrl_rdata, ctrl_ready,
      output ready, rdata, data_valid, data_addr, data_valid_reg, data_addr_reg,
             data_wdata_reg, data_wstrb_reg, ctrl_valid, ctrl_addr, grant_id
   );
endinterface

// File: rtl/cache_front_end_arb.sv
// Round-robin arbiter merging N_PORTS native requesters onto one cache memory / cache-control
// back-end, with the stored-request stage the cache pipeline consumes.
module cache_front_end_arb #(
   parameter int FE_ADDR_W   = 32,
   parameter int FE_DATA_W   = 32,
   parameter int N_PORTS     = 2,
   parameter int CTRL_CACHE  = 0,
   parameter int CTRL_ADDR_W = 5
) (
   input logic                  clk,
   input logic                  reset,
   cache_front_end_arb_if.slave bus
);
   localparam int FE_NBYTES = FE_DATA_W / 8;
   localparam int FE_BYTE_W = $clog2(FE_NBYTES);
   localparam int PTR_W     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
   localparam int AW        = CTRL_CACHE + FE_ADDR_W;
   localparam int WA_W      = FE_ADDR_W - FE_BYTE_W;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                 state_q, state_d;
   logic [PTR_W-1:0]       ptr_q, ptr_d;
   logic [PTR_W-1:0]       grant_q, grant_d;
   logic                   valid_reg_q, valid_reg_d;
   logic [WA_W-1:0]        addr_reg_q, addr_reg_d;
   logic [FE_DATA_W-1:0]   wdata_reg_q, wdata_reg_d;
   logic [FE_NBYTES-1:0]   wstrb_reg_q, wstrb_reg_d;

   logic [AW-1:0]          p_addr  [N_PORTS];
   logic [FE_DATA_W-1:0]   p_wdata [N_PORTS];
   logic [FE_NBYTES-1:0]   p_wstrb [N_PORTS];

   logic [PTR_W-1:0]       rr_sel;
   logic [PTR_W-1:0]       sel;
   logic                   any_req;
   logic                   is_ctrl;
   logic                   req_on;
   logic                   done;
   logic [AW-1:0]          sel_addr;
   logic [FE_DATA_W-1:0]   resp;
   logic [N_PORTS-1:0]           ready_v;
   logic [N_PORTS*FE_DATA_W-1:0] rdata_v;

   for (genvar i = 0; i < N_PORTS; i++) begin : g_slice
      assign p_addr[i]  = bus.addr[i*AW +: AW];
      assign p_wdata[i] = bus.wdata[i*FE_DATA_W +: FE_DATA_W];
      assign p_wstrb[i] = bus.wstrb[i*FE_NBYTES +: FE_NBYTES];
   end

   // First valid port scanning upward from ptr, wrapping; defaults to ptr when none is valid.
   always_comb begin
      int  idx;
      logic found;
      rr_sel = ptr_q;
      found  = 1'b0;
      idx    = 0;
      for (int k = 0; k < N_PORTS; k++) begin
         idx = (int'(ptr_q) + k) % N_PORTS;
         if (!found && bus.valid[idx]) begin
            rr_sel = PTR_W'(idx);
            found  = 1'b1;
         end
      end
   end

   // Arbitration is held off while reset is asserted so nothing is offered to the back-end.
   assign any_req  = (|bus.valid) & reset;
   assign sel      = (state_q == BUSY) ? grant_q : rr_sel;
   assign sel_addr = p_addr[sel];
   assign is_ctrl  = (CTRL_CACHE != 0) && sel_addr[AW-1];
   assign resp     = is_ctrl ? bus.ctrl_rdata : bus.data_rdata;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      grant_d     = grant_q;
      valid_reg_d = valid_reg_q;
      addr_reg_d  = addr_reg_q;
      wdata_reg_d = wdata_reg_q;
      wstrb_reg_d = wstrb_reg_q;
      req_on      = 1'b0;
      done        = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               req_on      = 1'b1;
               state_d     = BUSY;
               grant_d     = rr_sel;
               valid_reg_d = 1'b1;
               addr_reg_d  = sel_addr[FE_BYTE_W +: WA_W];
               wdata_reg_d = p_wdata[rr_sel];
               wstrb_reg_d = p_wstrb[rr_sel];
            end
         end
         BUSY: begin
            req_on = 1'b1;
            done   = is_ctrl ? bus.ctrl_ready : bus.data_ready;
            if (done) begin
               state_d     = IDLE;
               valid_reg_d = 1'b0;
               ptr_d       = (grant_q == PTR_W'(N_PORTS - 1)) ? '0 : grant_q + PTR_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ready_v = '0;
      rdata_v = '0;
      if (done) begin
         ready_v[grant_q]                                  = 1'b1;
         rdata_v[int'(grant_q)*FE_DATA_W +: FE_DATA_W]     = resp;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         grant_q     <= '0;
         valid_reg_q <= 1'b0;
         addr_reg_q  <= '0;
         wdata_reg_q <= '0;
         wstrb_reg_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         grant_q     <= grant_d;
         valid_reg_q <= valid_reg_d;
         addr_reg_q  <= addr_reg_d;
         wdata_reg_q <= wdata_reg_d;
         wstrb_reg_q <= wstrb_reg_d;
      end
   end

   assign bus.ready          = ready_v;
   assign bus.rdata          = rdata_v;
   assign bus.data_valid     = req_on & ~is_ctrl;
   assign bus.data_addr      = sel_addr[FE_BYTE_W +: WA_W];
   assign bus.data_valid_reg = valid_reg_q & ~is_ctrl;
   assign bus.data_addr_reg  = addr_reg_q;
   assign bus.data_wdata_reg = wdata_reg_q;
   assign bus.data_wstrb_reg = wstrb_reg_q;
   assign bus.ctrl_valid     = req_on & is_ctrl;
   assign bus.ctrl_addr      = (CTRL_CACHE != 0) ? sel_addr[FE_BYTE_W +: CTRL_ADDR_W] : '0;
   assign bus.grant_id       = sel;
endmodule

// File: tb/tb_cache_front_end_arb.sv
// Directed bench for the two-port arbiter with the cache-control path enabled.
module tb_cache_front_end_arb;
   localparam int AW = 33;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_fail;

   cache_front_end_arb_if #(.FE_ADDR_W(32), .FE_DATA_W(32), .N_PORTS(2),
                            .CTRL_CACHE(1), .CTRL_ADDR_W(5)) bus ();

   cache_front_end_arb #(.FE_ADDR_W(32), .FE_DATA_W(32), .N_PORTS(2),
                         .CTRL_CACHE(1), .CTRL_ADDR_W(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int p, input logic v, input logic [AW-1:0] a,
                           input logic [31:0] d, input logic [3:0] s);
      bus.valid[p]          = v;
      bus.addr[p*AW +: AW]  = a;
      bus.wdata[p*32 +: 32] = d;
      bus.wstrb[p*4 +: 4]   = s;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      reset  = 1'b0;
      bus.valid = '0; bus.addr = '0; bus.wdata = '0; bus.wstrb = '0;
      bus.data_rdata = '0; bus.data_ready = 1'b0;
      bus.ctrl_rdata = '0; bus.ctrl_ready = 1'b0;
      #3;
      chk("rst_ready", 64'(bus.ready), 64'h0);
      chk("rst_rdata", bus.rdata, 64'h0);
      chk("rst_dvalid", 64'(bus.data_valid), 64'h0);
      chk("rst_cvalid", 64'(bus.ctrl_valid), 64'h0);
      chk("rst_vreg", 64'(bus.data_valid_reg), 64'h0);
      chk("rst_grant", 64'(bus.grant_id), 64'h0);
      chk("rst_wdreg", 64'(bus.data_wdata_reg), 64'h0);
      tick();
      reset = 1'b1;
      tick();

      // Stray data_ready while idle
      bus.data_ready = 1'b1;
      #2;
      chk("idle_rdy_ready", 64'(bus.ready), 64'h0);
      tick();
      bus.data_ready = 1'b0;
      #2;
      chk("idle_rdy_vreg", 64'(bus.data_valid_reg), 64'h0);
      chk("idle_rdy_dvalid", 64'(bus.data_valid), 64'h0);

      // Port 0 read at 0x40
      set_port(0, 1'b1, 33'h40, 32'h0, 4'h0);
      #2;
      chk("rd_dvalid_idle", 64'(bus.data_valid), 64'h1);
      chk("rd_daddr", 64'(bus.data_addr), 64'h10);
      chk("rd_grant", 64'(bus.grant_id), 64'h0);
      chk("rd_vreg_idle", 64'(bus.data_valid_reg), 64'h0);
      chk("rd_cvalid", 64'(bus.ctrl_valid), 64'h0);
      tick();
      #2;
      chk("rd_vreg_busy", 64'(bus.data_valid_reg), 64'h1);
      chk("rd_areg", 64'(bus.data_addr_reg), 64'h10);
      chk("rd_ready_wait", 64'(bus.ready), 64'h0);
      tick();
      bus.data_ready = 1'b1;
      bus.data_rdata = 32'hDEADBEEF;
      #2;
      chk("rd_ready", 64'(bus.ready), 64'h1);
      chk("rd_rdata", bus.rdata, 64'h0000_0000_DEAD_BEEF);
      tick();
      bus.data_ready = 1'b0;
      set_port(0, 1'b0, 33'h0, 32'h0, 4'h0);
      #2;
      chk("rd_vreg_clr", 64'(bus.data_valid_reg), 64'h0);
      chk("rd_ready_clr", 64'(bus.ready), 64'h0);

      // Port 1 write; pointer now favours port 1
      set_port(1, 1'b1, 33'h80, 32'hA5A5A5A5, 4'hF);
      #2;
      chk("wr_grant", 64'(bus.grant_id), 64'h1);
      tick();
      #2;
      chk("wr_wdreg", 64'(bus.data_wdata_reg), 64'hA5A5A5A5);
      chk("wr_wsreg", 64'(bus.data_wstrb_reg), 64'hF);
      tick();
      #2;
      chk("wr_wdreg_hold", 64'(bus.data_wdata_reg), 64'hA5A5A5A5);
      chk("wr_wsreg_hold", 64'(bus.data_wstrb_reg), 64'hF);
      bus.data_ready = 1'b1;
      bus.data_rdata = 32'h12345678;
      #1;
      chk("wr_ready", 64'(bus.ready), 64'h2);
      chk("wr_rdata", bus.rdata, 64'h1234_5678_0000_0000);
      tick();
      bus.data_ready = 1'b0;
      set_port(1, 1'b0, 33'h0, 32'h0, 4'h0);

      // Both ports continuously valid: grants alternate with an idle bubble
      set_port(0, 1'b1, 33'h100, 32'h0, 4'h0);
      set_port(1, 1'b1, 33'h200, 32'h0, 4'h0);
      for (int t = 0; t < 4; t++) begin
         #2;
         chk("rr_grant", 64'(bus.grant_id), (t % 2 == 0) ? 64'h0 : 64'h1);
         chk("rr_daddr", 64'(bus.data_addr), (t % 2 == 0) ? 64'h40 : 64'h80);
         chk("rr_bubble", 64'(bus.data_valid_reg), 64'h0);
         tick();
         bus.data_ready = 1'b1;
         #2;
         chk("rr_ready", 64'(bus.ready), (t % 2 == 0) ? 64'h1 : 64'h2);
         tick();
         bus.data_ready = 1'b0;
      end
      set_port(0, 1'b0, 33'h0, 32'h0, 4'h0);
      set_port(1, 1'b0, 33'h0, 32'h0, 4'h0);
      #2;
      tick();

      // Cache-control access from port 0: MSB set, addr[6:2] = 3
      set_port(0, 1'b1, {1'b1, 32'h0000_000C}, 32'h0, 4'h0);
      #2;
      chk("ct_cvalid", 64'(bus.ctrl_valid), 64'h1);
      chk("ct_caddr", 64'(bus.ctrl_addr), 64'h3);
      chk("ct_dvalid", 64'(bus.data_valid), 64'h0);
      tick();
      bus.data_ready = 1'b1;
      #2;
      chk("ct_wrong_rdy", 64'(bus.ready), 64'h0);
      chk("ct_cvalid_busy", 64'(bus.ctrl_valid), 64'h1);
      chk("ct_vreg", 64'(bus.data_valid_reg), 64'h0);
      tick();
      bus.data_ready = 1'b0;
      bus.ctrl_ready = 1'b1;
      bus.ctrl_rdata = 32'd7;
      #2;
      chk("ct_ready", 64'(bus.ready), 64'h1);
      chk("ct_rdata", bus.rdata, 64'h7);
      tick();
      bus.ctrl_ready = 1'b0;
      set_port(0, 1'b0, 33'h0, 32'h0, 4'h0);
      #2;
      tick();

      // Reset while port 1 is being served
      set_port(1, 1'b1, 33'h300, 32'h55, 4'h0);
      #2;
      chk("mr_grant", 64'(bus.grant_id), 64'h1);
      tick();
      #2;
      chk("mr_vreg_busy", 64'(bus.data_valid_reg), 64'h1);
      reset = 1'b0;
      set_port(1, 1'b0, 33'h0, 32'h0, 4'h0);
      bus.data_ready = 1'b1;
      #2;
      chk("mr_ready", 64'(bus.ready), 64'h0);
      chk("mr_vreg", 64'(bus.data_valid_reg), 64'h0);
      chk("mr_dvalid", 64'(bus.data_valid), 64'h0);
      chk("mr_areg", 64'(bus.data_addr_reg), 64'h0);
      chk("mr_wdreg", 64'(bus.data_wdata_reg), 64'h0);
      tick();
      tick();
      reset = 1'b1;
      #2;
      chk("mr_rel_ready", 64'(bus.ready), 64'h0);
      tick();
      #2;
      chk("mr_rel_ready2", 64'(bus.ready), 64'h0);
      bus.data_ready = 1'b0;
      bus.valid = 2'b11;
      #2;
      chk("mr_ptr0", 64'(bus.grant_id), 64'h0);
      bus.valid = 2'b00;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
